// File: rtl/fact_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fact_sched_pkg                                                       |
// | Shared state encoding and defaults for the factorial scheduler.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package fact_sched_pkg;

  // Scheduler sequence: capture, launch the unit, wait for it, return result
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam int IW_DEFAULT = 4;
  localparam int DW_DEFAULT = 32;
  // Largest operand the factorial unit handles without raising its error
  localparam int FACT_MAX_N = 12;

endpackage
`default_nettype wire

// File: rtl/fact_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fact_sched_if                                                        |
// | Requester, factorial-unit and response signals of the scheduler.     |
// | slave = scheduler side, master = requesters/unit/consumer side.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface fact_sched_if
  import fact_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = IW_DEFAULT,
  parameter int DW    = DW_DEFAULT
) ();
  localparam int c_idw = $clog2(N_REQ);

  logic [N_REQ-1:0]    req;
  logic [N_REQ*IW-1:0] req_n;
  logic [N_REQ-1:0]    ack;
  logic                fu_go;
  logic [IW-1:0]       fu_n;
  logic                fu_done;
  logic                fu_err;
  logic [DW-1:0]       fu_y;
  logic                resp_valid;
  logic                resp_ready;
  logic [c_idw-1:0]    resp_id;
  logic [DW-1:0]       resp_y;
  logic                resp_err;

  modport slave (
    input  req, req_n, fu_done, fu_err, fu_y, resp_ready,
    output ack, fu_go, fu_n, resp_valid, resp_id, resp_y, resp_err
  );

  modport master (
    output req, req_n, fu_done, fu_err, fu_y, resp_ready,
    input  ack, fu_go, fu_n, resp_valid, resp_id, resp_y, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/fact_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fact_rr_pick                                                         |
// | Combinational round-robin winner search starting after 'last'.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module fact_rr_pick #(
  parameter  int N_REQ = 4,
  localparam int c_idw = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [c_idw-1:0] last,
  output logic [c_idw-1:0] winner,
  output logic             any
);

  // Scan from the farthest position down to the nearest so the requester
  // closest after 'last' is the one left in 'winner'.
  always_comb begin
    winner = '0;
    any    = |req;
    for (int k = N_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last) + k) % N_REQ;
      if (req[c_idw'(idx)]) winner = c_idw'(idx);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fact_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fact_sched                                                           |
// | Round-robin scheduler sharing one factorial unit among N_REQ         |
// | requesters; returns each result over a valid/ready response port.    |
// | Optional WAIT timeout: define FACT_SCHED_TIMEOUT_EN.                 |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module fact_sched
  import fact_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = IW_DEFAULT,
  parameter int DW    = DW_DEFAULT
`ifdef FACT_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input logic         clk,
  input logic         rst,
  fact_sched_if.slave bus
);

  localparam int c_idw = $clog2(N_REQ);

  state_t           r_state;
  state_t           w_next;
  logic [c_idw-1:0] r_id;
  logic [c_idw-1:0] r_last;
  logic [IW-1:0]    r_n;
  logic [DW-1:0]    r_y;
  logic             r_err;
  logic [c_idw-1:0] w_win;
  logic             w_any;
  logic             w_timeout;

  fact_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (bus.req),
    .last   (r_last),
    .winner (w_win),
    .any    (w_any)
  );

`ifdef FACT_SCHED_TIMEOUT_EN
  localparam int c_cw = $clog2(TIMEOUT);
  logic [c_cw-1:0] r_wcnt;

  // WAIT-cycle counter: zeroed while launching so it starts at 0 in WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_wcnt <= '0;
    else if (r_state != S_WAIT) r_wcnt <= '0;
    else                        r_wcnt <= r_wcnt + 1'b1;
  end

  assign w_timeout = (r_state == S_WAIT) && (r_wcnt == c_cw'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: unit pulses are only looked at while in WAIT
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT:   if (bus.fu_err || bus.fu_done || w_timeout) w_next = S_RESP;
      S_RESP:   if (bus.resp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Job capture, result latch and round-robin pointer update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id   <= '0;
      r_n    <= '0;
      r_last <= c_idw'(N_REQ - 1);
      r_y    <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id <= w_win;
            r_n  <= bus.req_n[int'(w_win)*IW +: IW];
          end
        end
        S_WAIT: begin
          // Error beats a simultaneous done; a real pulse beats the timeout
          if (bus.fu_err) begin
            r_y   <= '0;
            r_err <= 1'b1;
          end else if (bus.fu_done) begin
            r_y   <= bus.fu_y;
            r_err <= 1'b0;
          end else if (w_timeout) begin
            r_y   <= '0;
            r_err <= 1'b1;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) r_last <= r_id;
        end
        default: ;
      endcase
    end
  end

  assign bus.fu_go      = (r_state == S_LAUNCH);
  assign bus.ack        = (r_state == S_LAUNCH) ? (N_REQ'(1) << r_id) : '0;
  assign bus.fu_n       = r_n;
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_id    = r_id;
  assign bus.resp_y     = r_y;
  assign bus.resp_err   = r_err;

endmodule
`default_nettype wire
